// File: rtl/alu_ctrl_pkg.sv
// ALU control codes, sequencer state encoding and op classification helper
// shared by the ALU share sequencer and its testbench.
// No ports; pure declarations.
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_NEG   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_XOR   = 4'b0011;
    localparam logic [3:0] ALU_SHLL  = 4'b0100;
    localparam logic [3:0] ALU_SHRL  = 4'b0101;
    localparam logic [3:0] ALU_SHRA  = 4'b0110;
    localparam logic [3:0] ALU_BYPA  = 4'b0111;
    localparam logic [3:0] ALU_BYPB  = 4'b1000;
    localparam logic [3:0] ALU_ADDI  = 4'b1001;
    localparam logic [3:0] ALU_MULT  = 4'b1010;
    localparam logic [3:0] ALU_MULTU = 4'b1011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } seq_state_t;

    // Multiplies need the ALU inputs held for several cycles.
    function automatic logic is_mul(input logic [3:0] ctrl);
        return (ctrl == ALU_MULT) || (ctrl == ALU_MULTU);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; combinational, zero latency.
// Ports: req[1:0] requests, last_grant = port granted last time, gnt[1:0] one-hot or zero.
// On contention the port that did not win last time is granted.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_share_sequencer.sv
// Shares one combinational ALU between two requesters with round-robin arbitration.
// Latency: result valid 2 edges after accept (1+MUL_LATENCY for mult/multu).
// Backpressure: one op in flight; result held until resp_ready, no accept while busy.
// Ports: req0_*/req1_* valid/ready request ports (op1, op2, ctrl);
//        alu_inp1/alu_inp2/alu_control drive the ALU, alu_out/alu_high/alu_flags return from it;
//        resp_* valid/ready result port tagged with resp_id; busy when not IDLE.
module alu_share_sequencer #(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_op1,
    input  logic [WIDTH-1:0] req0_op2,
    input  logic [3:0]       req0_ctrl,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_op1,
    input  logic [WIDTH-1:0] req1_op2,
    input  logic [3:0]       req1_ctrl,
    output logic [WIDTH-1:0] alu_inp1,
    output logic [WIDTH-1:0] alu_inp2,
    output logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [WIDTH-1:0] alu_high,
    input  logic [3:0]       alu_flags,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_out,
    output logic [WIDTH-1:0] resp_high,
    output logic [3:0]       resp_flags,
    output logic             busy
);

    import alu_ctrl_pkg::*;

    localparam logic [3:0] CNT_LOAD = 4'(MUL_LATENCY - 1);

    seq_state_t state, state_nxt;
    logic [1:0] gnt;
    logic       last_grant;
    logic       cur_id;
    logic [3:0] mul_cnt;
    logic       accept;
    logic       capture;

    logic [WIDTH-1:0] sel_op1, sel_op2;
    logic [3:0]       sel_ctrl;

    rr_arbiter2 u_arb (
        .req        ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .gnt        (gnt)
    );

    assign sel_op1  = gnt[1] ? req1_op1  : req0_op1;
    assign sel_op2  = gnt[1] ? req1_op2  : req0_op2;
    assign sel_ctrl = gnt[1] ? req1_ctrl : req0_ctrl;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = gnt[0];
                req1_ready = gnt[1];
                // A grant only goes to a valid port, so any grant is a handshake.
                if (gnt != 2'b00) begin
                    accept    = 1'b1;
                    state_nxt = is_mul(sel_ctrl) ? MUL : EXEC;
                end
            end
            EXEC: begin
                capture   = 1'b1;
                state_nxt = DONE;
            end
            MUL: begin
                if (mul_cnt == 4'd0) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_inp1    <= '0;
            alu_inp2    <= '0;
            alu_control <= ALU_ADD;
            cur_id      <= 1'b0;
            last_grant  <= 1'b1;
            mul_cnt     <= 4'd0;
            resp_id     <= 1'b0;
            resp_out    <= '0;
            resp_high   <= '0;
            resp_flags  <= 4'd0;
        end else begin
            if (accept) begin
                alu_inp1    <= sel_op1;
                alu_inp2    <= sel_op2;
                alu_control <= sel_ctrl;
                cur_id      <= gnt[1];
                last_grant  <= gnt[1];
                mul_cnt     <= CNT_LOAD;
            end else if ((state == MUL) && (mul_cnt != 4'd0)) begin
                mul_cnt <= mul_cnt - 4'd1;
            end
            if (capture) begin
                resp_id    <= cur_id;
                resp_out   <= alu_out;
                resp_flags <= alu_flags;
                // HI is only meaningful for multiplies; other ops leave it alone.
                if (state == MUL) begin
                    resp_high <= alu_high;
                end
            end
        end
    end

    assign resp_valid = (state == DONE);
    assign busy       = (state != IDLE);

endmodule
